qdr_multiport_arbiter: RTL and testbench
========================================

Name: qdr_multiport_arbiter

Overview:
Shares one QDR controller user interface (usr_* strobe bus, 36-bit data, 22-bit address) among NUM_PORTS independent client ports. Arbitration is round-robin. Read returns are routed back to the issuing port through an in-order tag FIFO. The block sits between the DSP/readout clients and the qdr controller wrapper, in the controller's user clock domain.

Parameters:
NUM_PORTS, 4, number of client ports (2..8)
ADDR_WIDTH, 22, usr_addr width
DATA_WIDTH, 36, usr_wr_data / usr_rd_data width
BE_WIDTH, 4, byte-enable width
TAG_DEPTH, 16, max outstanding reads (power of 2)
RD_TIMEOUT, 255, cycles allowed for the oldest read to return (used only with the optional feature)

Ports:
clk0  in  1  user clock, shared with the qdr controller
reset_n  in  1  asynchronous, active-low reset
phy_rdy  in  1  controller calibrated; no grants while low
p_req  in  NUM_PORTS  per-port request, held until acked
p_rnw  in  NUM_PORTS  1=read, 0=write
p_addr  in  NUM_PORTS*ADDR_WIDTH  packed addresses, port 0 in LSBs
p_wr_data  in  NUM_PORTS*DATA_WIDTH  packed write data
p_wr_be  in  NUM_PORTS*BE_WIDTH  packed byte enables
p_ack  out  NUM_PORTS  one-hot grant, combinational
p_rd_data  out  DATA_WIDTH  registered read data, broadcast to all ports
p_rd_dvld  out  NUM_PORTS  one-hot read-valid, qualifies p_rd_data
usr_addr  out  ADDR_WIDTH  to controller
usr_wr_strb  out  1  to controller
usr_wr_data  out  DATA_WIDTH  to controller
usr_wr_be  out  BE_WIDTH  to controller
usr_rd_strb  out  1  to controller
usr_rd_data  in  DATA_WIDTH  from controller
usr_rd_dvld  in  1  from controller
rd_outstanding  out  log2(TAG_DEPTH)+1  reads in flight
err_underflow  out  1  sticky: usr_rd_dvld arrived with no outstanding read

Behaviour:
- Reset values: all outputs 0; RR pointer = 0; tag FIFO empty.
- Eligibility: port i is eligible when p_req[i] & phy_rdy & (p_rnw[i]==0 | tag FIFO not full).
- Grant: first eligible port at or after the RR pointer, wrapping modulo NUM_PORTS. At most one grant per cycle. p_ack[grant] is asserted in the same cycle. On a grant, the pointer moves to grant+1 (wraps NUM_PORTS-1 -> 0). With no grant, the pointer holds.
- Issue latency: the command granted in cycle t drives usr_addr, usr_wr_data, usr_wr_be and exactly one of usr_wr_strb / usr_rd_strb in cycle t+1. Strobes last one cycle. Data/addr outputs hold their last value when idle.
- Client handshake: the client must drop p_req or present a new request in the cycle after ack. Back-to-back grants to the same port are legal when it is the only eligible port.
- Read tagging: a read issue pushes the port index into the tag FIFO in cycle t+1.
- Read return: usr_rd_dvld in cycle u pops the FIFO head. p_rd_dvld[head] and p_rd_data = usr_rd_data are driven in cycle u+1. Returns are strictly in issue order.
- Simultaneous push and pop: both happen; rd_outstanding is unchanged.
- FIFO full (rd_outstanding == TAG_DEPTH): reads are ineligible; writes still arbitrate. A pop in the same cycle does not unblock reads until the next cycle.
- Empty-FIFO dvld: no p_rd_dvld is asserted; err_underflow sets to 1 and stays set until reset.
- phy_rdy falls: no new grants. An already-registered issue still goes out. Outstanding reads are still routed.
- Reset mid-operation: pointer and FIFO are cleared immediately; in-flight reads are discarded. A controller return arriving after reset release sets err_underflow (expected; software clears it by resetting again).

Optional Feature:
QDR_ARB_RD_TIMEOUT_EN
- Defined:
  - A counter runs while rd_outstanding != 0. It reloads on every pop and clears when the FIFO empties.
  - When the counter reaches RD_TIMEOUT, the FIFO is flushed.
  - Extra output err_timeout (1 bit, sticky, reset 0) is set.
  - Returns arriving after the flush set err_underflow.
- Undefined: no counter, no err_timeout port; reads wait indefinitely.

Decomposition:
- Package qdr_arb_pkg:
  - function clog2
  - typedef for port index (width clog2(NUM_PORTS))
  - command-type encoding constants CMD_WR=0, CMD_RD=1
  - default widths matching the qdr controller (36/22/4)
- Sub-module qdr_tag_fifo:
  - synchronous FIFO of port indices, TAG_DEPTH entries
  - full, empty, count outputs
  - flush input (used only by the timeout feature)

Test Plan:
1. Ports 0..3 all request writes every cycle, phy_rdy=1 -> acks 0,1,2,3,0,... one per cycle; usr_wr_strb high every cycle from t+1; usr_addr matches the granted port's p_addr.
2. Port 2 reads addr 0x000100 and port 1 reads 0x000200; controller returns 0xA and 0xB six cycles later on consecutive cycles -> p_rd_dvld[2] with 0xA, then p_rd_dvld[1] with 0xB, each one cycle after its usr_rd_dvld.
3. 16 reads issued with no returns (TAG_DEPTH=16); port 0 read and port 3 write then pending -> rd_outstanding=16, port 3 write granted, port 0 unacked until the first return, then granted the cycle after.
4. usr_rd_dvld pulsed with FIFO empty -> no p_rd_dvld, err_underflow=1 and held until reset_n=0.
5. phy_rdy=0 with all ports requesting for 10 cycles -> p_ack=0, no strobes; phy_rdy=1 -> grants resume from the held pointer.
6. With QDR_ARB_RD_TIMEOUT_EN, RD_TIMEOUT=20: one read, no return for 25 cycles -> at cycle 20 rd_outstanding=0 and err_timeout=1; a late return sets err_underflow.

Source files
------------

// File: rtl/qdr_arb_pkg.sv
// Shared types, widths and helpers for the QDR multiport arbiter.
package qdr_arb_pkg;

    localparam int unsigned DEF_DATA_W = 36;
    localparam int unsigned DEF_ADDR_W = 22;
    localparam int unsigned DEF_BE_W   = 4;
    localparam int unsigned MAX_PORTS  = 8;

    localparam logic CMD_WR = 1'b0;
    localparam logic CMD_RD = 1'b1;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = 32'(i + 1);
        end
        return r;
    endfunction

    localparam int unsigned PORT_IDX_W = clog2(MAX_PORTS);
    typedef logic [PORT_IDX_W-1:0] port_idx_t;

endpackage

// File: rtl/qdr_tag_fifo.sv
// In-order FIFO of issuing port indices for outstanding reads; flush empties it in one cycle.
module qdr_tag_fifo
    import qdr_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  port_idx_t              i_push_idx,
    input  logic                   i_pop,
    input  logic                   i_flush,
    output port_idx_t              o_head_c,
    output logic                   o_full_c,
    output logic                   o_empty_c,
    output logic [clog2(DEPTH):0]  o_count
);

    localparam int unsigned PW = clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    port_idx_t       r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic            w_push_ok;
    logic            w_pop_ok;

    assign o_full_c  = (o_count == CW'(DEPTH));
    assign o_empty_c = (o_count == '0);
    assign o_head_c  = r_mem[r_rd_ptr];
    assign w_pop_ok  = i_pop && !o_empty_c;
    assign w_push_ok = i_push && (!o_full_c || w_pop_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            o_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            o_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_push_ok && !w_pop_ok)      o_count <= o_count + CW'(1);
            else if (w_pop_ok && !w_push_ok) o_count <= o_count - CW'(1);
        end
    end

    // Storage needs no reset: entries are only read once pushed.
    always_ff @(posedge clk) begin
        if (w_push_ok && !i_flush) r_mem[r_wr_ptr] <= i_push_idx;
    end

endmodule

// File: rtl/qdr_multiport_arbiter.sv
// Round-robin arbiter sharing one QDR controller user port among NUM_PORTS clients.
// Optional read-return timeout with flush and err_timeout: define QDR_ARB_RD_TIMEOUT_EN.
module qdr_multiport_arbiter
    import qdr_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS  = 4,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_W,
    parameter int unsigned DATA_WIDTH = DEF_DATA_W,
    parameter int unsigned BE_WIDTH   = DEF_BE_W,
    parameter int unsigned TAG_DEPTH  = 16,
    parameter int unsigned RD_TIMEOUT = 255
) (
    input  logic                            clk0,
    input  logic                            reset_n,
    input  logic                            phy_rdy,
    input  logic [NUM_PORTS-1:0]            p_req,
    input  logic [NUM_PORTS-1:0]            p_rnw,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] p_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] p_wr_data,
    input  logic [NUM_PORTS*BE_WIDTH-1:0]   p_wr_be,
    output logic [NUM_PORTS-1:0]            p_ack,
    output logic [DATA_WIDTH-1:0]           p_rd_data,
    output logic [NUM_PORTS-1:0]            p_rd_dvld,
    output logic [ADDR_WIDTH-1:0]           usr_addr,
    output logic                            usr_wr_strb,
    output logic [DATA_WIDTH-1:0]           usr_wr_data,
    output logic [BE_WIDTH-1:0]             usr_wr_be,
    output logic                            usr_rd_strb,
    input  logic [DATA_WIDTH-1:0]           usr_rd_data,
    input  logic                            usr_rd_dvld,
    output logic [clog2(TAG_DEPTH):0]       rd_outstanding,
    output logic                            err_underflow
`ifdef QDR_ARB_RD_TIMEOUT_EN
    ,
    output logic                            err_timeout
`endif
);

    localparam int unsigned CW  = clog2(TAG_DEPTH) + 1;
    localparam int unsigned CW1 = CW + 1;

    if (NUM_PORTS < 2 || NUM_PORTS > MAX_PORTS) begin : g_bad_ports
        $error("NUM_PORTS must be 2..8");
    end
    if (TAG_DEPTH < 2 || (TAG_DEPTH & (TAG_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("TAG_DEPTH must be a power of 2, at least 2");
    end
    if (RD_TIMEOUT == 0) begin : g_bad_timeout
        $error("RD_TIMEOUT must be nonzero");
    end

    port_idx_t                r_ptr;
    port_idx_t                r_iss_idx;
    logic [NUM_PORTS-1:0]     w_elig;
    logic [NUM_PORTS-1:0]     w_ack;
    logic [NUM_PORTS-1:0]     w_head_oh;
    logic                     w_gnt_vld;
    port_idx_t                w_gnt_idx;
    int unsigned              w_best;
    int unsigned              w_dist;
    logic                     w_sel_rnw;
    logic [ADDR_WIDTH-1:0]    w_sel_addr;
    logic [DATA_WIDTH-1:0]    w_sel_data;
    logic [BE_WIDTH-1:0]      w_sel_be;
    logic                     w_rd_block;
    logic                     w_full;
    logic                     w_empty;
    logic                     w_pop;
    logic                     w_flush;
    port_idx_t                w_head;

    // A registered read not yet pushed still consumes a tag slot.
    assign w_rd_block = ({1'b0, rd_outstanding} + CW1'(usr_rd_strb)) >= CW1'(TAG_DEPTH);
    assign w_elig     = p_req & {NUM_PORTS{phy_rdy}} & (~p_rnw | {NUM_PORTS{~w_rd_block}});
    assign w_pop      = usr_rd_dvld && !w_empty;
    assign p_ack      = w_ack;

    // Grant the eligible port nearest at-or-after the RR pointer, then mux its command.
    always_comb begin
        w_gnt_vld  = 1'b0;
        w_gnt_idx  = '0;
        w_best     = NUM_PORTS;
        w_dist     = 0;
        w_ack      = '0;
        w_sel_rnw  = CMD_WR;
        w_sel_addr = '0;
        w_sel_data = '0;
        w_sel_be   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_dist = (32'(i) + NUM_PORTS - 32'(r_ptr)) % NUM_PORTS;
            if (w_elig[i] && w_dist < w_best) begin
                w_best    = w_dist;
                w_gnt_vld = 1'b1;
                w_gnt_idx = port_idx_t'(i);
            end
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (w_gnt_vld && w_gnt_idx == port_idx_t'(i)) begin
                w_ack[i]   = 1'b1;
                w_sel_rnw  = p_rnw[i];
                w_sel_addr = p_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_data = p_wr_data[i*DATA_WIDTH +: DATA_WIDTH];
                w_sel_be   = p_wr_be[i*BE_WIDTH +: BE_WIDTH];
            end
        end
    end

    always_comb begin
        w_head_oh = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_head_oh[i] = (w_head == port_idx_t'(i));
        end
    end

    // Issue stage: command granted this cycle goes to the controller next cycle.
    always_ff @(posedge clk0 or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr       <= '0;
            r_iss_idx   <= '0;
            usr_addr    <= '0;
            usr_wr_data <= '0;
            usr_wr_be   <= '0;
            usr_wr_strb <= 1'b0;
            usr_rd_strb <= 1'b0;
        end else begin
            usr_wr_strb <= w_gnt_vld && (w_sel_rnw == CMD_WR);
            usr_rd_strb <= w_gnt_vld && (w_sel_rnw == CMD_RD);
            if (w_gnt_vld) begin
                r_ptr       <= port_idx_t'((32'(w_gnt_idx) + 1) % NUM_PORTS);
                r_iss_idx   <= w_gnt_idx;
                usr_addr    <= w_sel_addr;
                usr_wr_data <= w_sel_data;
                usr_wr_be   <= w_sel_be;
            end
        end
    end

    // Return stage: route data to the oldest reader, flag returns with nothing outstanding.
    always_ff @(posedge clk0 or negedge reset_n) begin
        if (!reset_n) begin
            p_rd_dvld     <= '0;
            p_rd_data     <= '0;
            err_underflow <= 1'b0;
        end else begin
            p_rd_dvld <= w_pop ? w_head_oh : '0;
            if (w_pop) p_rd_data <= usr_rd_data;
            if (usr_rd_dvld && w_empty) err_underflow <= 1'b1;
        end
    end

`ifdef QDR_ARB_RD_TIMEOUT_EN
    localparam int unsigned TO_W = clog2(RD_TIMEOUT + 1);
    logic [TO_W-1:0] r_to_cnt;

    assign w_flush = (rd_outstanding != '0) && (r_to_cnt == TO_W'(RD_TIMEOUT));

    // Age of the oldest outstanding read; restarts on every return.
    always_ff @(posedge clk0 or negedge reset_n) begin
        if (!reset_n) begin
            r_to_cnt    <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (rd_outstanding == '0 || w_pop || w_flush) r_to_cnt <= '0;
            else                                          r_to_cnt <= r_to_cnt + TO_W'(1);
            if (w_flush) err_timeout <= 1'b1;
        end
    end
`else
    assign w_flush = 1'b0;
`endif

    qdr_tag_fifo #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk        (clk0),
        .rst_n      (reset_n),
        .i_push     (usr_rd_strb),
        .i_push_idx (r_iss_idx),
        .i_pop      (usr_rd_dvld),
        .i_flush    (w_flush),
        .o_head_c   (w_head),
        .o_full_c   (w_full),
        .o_empty_c  (w_empty),
        .o_count    (rd_outstanding)
    );

    logic w_unused;
    assign w_unused = w_full;

endmodule

// File: tb/tb_qdr_multiport_arbiter.sv
// Directed self-checking bench for qdr_multiport_arbiter (4 ports, 16 tags).
// Builds with or without QDR_ARB_RD_TIMEOUT_EN; the timeout scenario runs only when defined.
module tb_qdr_multiport_arbiter;

    localparam int NP = 4;
    localparam int AW = 22;
    localparam int DW = 36;
    localparam int BW = 4;

    logic             clk0 = 1'b0;
    logic             reset_n;
    logic             phy_rdy;
    logic [NP-1:0]    p_req;
    logic [NP-1:0]    p_rnw;
    logic [NP*AW-1:0] p_addr;
    logic [NP*DW-1:0] p_wr_data;
    logic [NP*BW-1:0] p_wr_be;
    logic [NP-1:0]    p_ack;
    logic [DW-1:0]    p_rd_data;
    logic [NP-1:0]    p_rd_dvld;
    logic [AW-1:0]    usr_addr;
    logic             usr_wr_strb;
    logic [DW-1:0]    usr_wr_data;
    logic [BW-1:0]    usr_wr_be;
    logic             usr_rd_strb;
    logic [DW-1:0]    usr_rd_data;
    logic             usr_rd_dvld;
    logic [4:0]       rd_outstanding;
    logic             err_underflow;
`ifdef QDR_ARB_RD_TIMEOUT_EN
    logic             err_timeout;
`endif

    int vectors     = 0;
    int miscompares = 0;

    qdr_multiport_arbiter #(
        .NUM_PORTS  (NP),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .BE_WIDTH   (BW),
        .TAG_DEPTH  (16),
        .RD_TIMEOUT (20)
    ) dut (
        .clk0           (clk0),
        .reset_n        (reset_n),
        .phy_rdy        (phy_rdy),
        .p_req          (p_req),
        .p_rnw          (p_rnw),
        .p_addr         (p_addr),
        .p_wr_data      (p_wr_data),
        .p_wr_be        (p_wr_be),
        .p_ack          (p_ack),
        .p_rd_data      (p_rd_data),
        .p_rd_dvld      (p_rd_dvld),
        .usr_addr       (usr_addr),
        .usr_wr_strb    (usr_wr_strb),
        .usr_wr_data    (usr_wr_data),
        .usr_wr_be      (usr_wr_be),
        .usr_rd_strb    (usr_rd_strb),
        .usr_rd_data    (usr_rd_data),
        .usr_rd_dvld    (usr_rd_dvld),
        .rd_outstanding (rd_outstanding),
        .err_underflow  (err_underflow)
`ifdef QDR_ARB_RD_TIMEOUT_EN
        ,
        .err_timeout    (err_timeout)
`endif
    );

    always #5 clk0 = ~clk0;

    function automatic logic [AW-1:0] addr_of(input int i);
        return 22'h02A000 + 22'(i) * 22'h000111;
    endfunction

    function automatic logic [DW-1:0] data_of(input int i);
        return 36'h9_0000_0000 + 36'(i) * 36'h0_0001_0101;
    endfunction

    task automatic tick;
        @(posedge clk0);
        #1;
    endtask

    task automatic set_port(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [BW-1:0] be);
        p_addr[i*AW +: AW]    = a;
        p_wr_data[i*DW +: DW] = d;
        p_wr_be[i*BW +: BW]   = be;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; phy_rdy = 1'b0; p_req = '0; p_rnw = '0;
        p_addr = '0; p_wr_data = '0; p_wr_be = '0;
        usr_rd_data = '0; usr_rd_dvld = 1'b0;
        #2;
        vectors++;
        if ({p_ack, p_rd_dvld, usr_wr_strb, usr_rd_strb, err_underflow} !== '0) begin
            miscompares++;
            $display("FAIL reset_ctl: ack=%b dvld=%b wr=%b rd=%b uf=%b, want all 0",
                     p_ack, p_rd_dvld, usr_wr_strb, usr_rd_strb, err_underflow);
        end
        vectors++;
        if ({usr_addr, usr_wr_data, usr_wr_be, p_rd_data, rd_outstanding} !== '0) begin
            miscompares++;
            $display("FAIL reset_data: addr=%h wd=%h be=%h rd=%h out=%0d, want all 0",
                     usr_addr, usr_wr_data, usr_wr_be, p_rd_data, rd_outstanding);
        end
        tick; tick;
        reset_n = 1'b1;
    endtask

    task automatic test_rr_writes;
        int p;
        logic [NP-1:0] exp_ack;
        phy_rdy = 1'b1; p_rnw = '0;
        for (int i = 0; i < NP; i++) set_port(i, addr_of(i), data_of(i), BW'(i + 1));
        p_req = '1;
        for (int c = 0; c < 9; c++) begin
            if (c == 8) p_req = '0;
            #1;
            exp_ack = (c < 8) ? NP'(1 << (c % NP)) : '0;
            vectors++;
            if (p_ack !== exp_ack) begin
                miscompares++;
                $display("FAIL rr_ack c=%0d: got %b want %b", c, p_ack, exp_ack);
            end
            if (c > 0) begin
                p = (c - 1) % NP;
                vectors++;
                if (usr_wr_strb !== 1'b1 || usr_rd_strb !== 1'b0 || usr_addr !== addr_of(p) ||
                    usr_wr_data !== data_of(p) || usr_wr_be !== BW'(p + 1)) begin
                    miscompares++;
                    $display("FAIL rr_issue c=%0d: wr=%b rd=%b addr=%h wd=%h be=%h want port %0d addr=%h",
                             c, usr_wr_strb, usr_rd_strb, usr_addr, usr_wr_data, usr_wr_be, p, addr_of(p));
                end
            end
            tick;
        end
        vectors++;
        if (usr_wr_strb !== 1'b0 || usr_addr !== addr_of(3)) begin
            miscompares++;
            $display("FAIL rr_idle_hold: wr=%b addr=%h want 0 / %h", usr_wr_strb, usr_addr, addr_of(3));
        end
    endtask

    task automatic test_reads;
        // Pointer is 0 here; port 2 issues first so it is the older read.
        p_req = 4'b0100; p_rnw = 4'b0100; set_port(2, 22'h000100, '0, '0);
        #1;
        vectors++;
        if (p_ack !== 4'b0100) begin
            miscompares++; $display("FAIL rd_ack2: got %b want 0100", p_ack);
        end
        tick;
        p_req = 4'b0010; p_rnw = 4'b0010; set_port(1, 22'h000200, '0, '0);
        #1;
        vectors++;
        if (p_ack !== 4'b0010 || usr_rd_strb !== 1'b1 || usr_wr_strb !== 1'b0 || usr_addr !== 22'h000100) begin
            miscompares++;
            $display("FAIL rd_issue2: ack=%b rd=%b wr=%b addr=%h want 0010/1/0/000100",
                     p_ack, usr_rd_strb, usr_wr_strb, usr_addr);
        end
        tick;
        p_req = '0;
        #1;
        vectors++;
        if (usr_rd_strb !== 1'b1 || usr_addr !== 22'h000200) begin
            miscompares++; $display("FAIL rd_issue1: rd=%b addr=%h want 1/000200", usr_rd_strb, usr_addr);
        end
        tick;
        vectors++;
        if (rd_outstanding !== 5'd2 || usr_rd_strb !== 1'b0) begin
            miscompares++; $display("FAIL rd_outstanding2: got %0d rd=%b want 2/0", rd_outstanding, usr_rd_strb);
        end
        repeat (4) tick;
        usr_rd_dvld = 1'b1; usr_rd_data = 36'hA;
        tick;
        usr_rd_data = 36'hB;
        vectors++;
        if (p_rd_dvld !== 4'b0100 || p_rd_data !== 36'hA) begin
            miscompares++; $display("FAIL rd_ret_A: dvld=%b data=%h want 0100/A", p_rd_dvld, p_rd_data);
        end
        tick;
        usr_rd_dvld = 1'b0;
        vectors++;
        if (p_rd_dvld !== 4'b0010 || p_rd_data !== 36'hB) begin
            miscompares++; $display("FAIL rd_ret_B: dvld=%b data=%h want 0010/B", p_rd_dvld, p_rd_data);
        end
        tick;
        vectors++;
        if (p_rd_dvld !== 4'b0000 || rd_outstanding !== 5'd0) begin
            miscompares++; $display("FAIL rd_drained: dvld=%b out=%0d want 0/0", p_rd_dvld, rd_outstanding);
        end
    endtask

    task automatic test_fifo_full;
        int bad;
        p_req = 4'b0001; p_rnw = 4'b0001; set_port(0, 22'h000300, '0, '0);
        bad = 0;
        for (int c = 0; c < 16; c++) begin
            #1;
            if (p_ack !== 4'b0001) bad++;
            tick;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++; $display("FAIL full_fill: %0d of 16 back-to-back reads not acked, want 0", bad);
        end
        p_req = 4'b1001; p_rnw = 4'b0001; set_port(3, 22'h000333, 36'h3_3333_3333, 4'hF);
        #1;
        vectors++;
        if (p_ack !== 4'b1000) begin
            miscompares++; $display("FAIL full_write_passes: ack=%b want 1000", p_ack);
        end
        tick;
        p_req = 4'b0001; usr_rd_dvld = 1'b1; usr_rd_data = 36'h123;
        #1;
        vectors++;
        if (rd_outstanding !== 5'd16 || p_ack !== 4'b0000 || usr_wr_strb !== 1'b1) begin
            miscompares++;
            $display("FAIL full_block: out=%0d ack=%b wr=%b want 16/0000/1", rd_outstanding, p_ack, usr_wr_strb);
        end
        tick;
        usr_rd_dvld = 1'b0;
        #1;
        vectors++;
        if (p_rd_dvld !== 4'b0001 || p_rd_data !== 36'h123 || rd_outstanding !== 5'd15 || p_ack !== 4'b0001) begin
            miscompares++;
            $display("FAIL full_unblock: dvld=%b data=%h out=%0d ack=%b want 0001/123/15/0001",
                     p_rd_dvld, p_rd_data, rd_outstanding, p_ack);
        end
        tick;
        p_req = '0;
        tick;
        vectors++;
        if (rd_outstanding !== 5'd16) begin
            miscompares++; $display("FAIL full_refill: out=%0d want 16", rd_outstanding);
        end
        bad = 0;
        for (int k = 0; k < 16; k++) begin
            usr_rd_dvld = 1'b1; usr_rd_data = 36'(k + 36'h500);
            tick;
            if (p_rd_dvld !== 4'b0001 || p_rd_data !== 36'(k + 36'h500)) bad++;
        end
        usr_rd_dvld = 1'b0;
        tick;
        vectors++;
        if (bad != 0 || rd_outstanding !== 5'd0) begin
            miscompares++; $display("FAIL full_drain: bad=%0d out=%0d want 0/0", bad, rd_outstanding);
        end
    endtask

    task automatic test_underflow;
        usr_rd_dvld = 1'b1; usr_rd_data = 36'hDEAD;
        tick;
        usr_rd_dvld = 1'b0;
        vectors++;
        if (p_rd_dvld !== 4'b0000 || err_underflow !== 1'b1) begin
            miscompares++; $display("FAIL uf_set: dvld=%b uf=%b want 0000/1", p_rd_dvld, err_underflow);
        end
        repeat (3) tick;
        vectors++;
        if (err_underflow !== 1'b1) begin
            miscompares++; $display("FAIL uf_sticky: uf=%b want 1", err_underflow);
        end
        reset_n = 1'b0;
        #1;
        vectors++;
        if (err_underflow !== 1'b0) begin
            miscompares++; $display("FAIL uf_reset: uf=%b want 0", err_underflow);
        end
        tick;
        reset_n = 1'b1;
    endtask

    task automatic test_phy_rdy;
        int bad;
        p_req = 4'b0001; p_rnw = '0;
        #1;
        vectors++;
        if (p_ack !== 4'b0001) begin
            miscompares++; $display("FAIL phy_pre: ack=%b want 0001", p_ack);
        end
        tick;
        phy_rdy = 1'b0; p_req = '1;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (p_ack !== 4'b0000) bad++;
            if (c == 0 && usr_wr_strb !== 1'b1) bad++;
            if (c > 0 && (usr_wr_strb !== 1'b0 || usr_rd_strb !== 1'b0)) bad++;
            tick;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++; $display("FAIL phy_low: %0d bad cycles, want 0", bad);
        end
        phy_rdy = 1'b1;
        #1;
        vectors++;
        if (p_ack !== 4'b0010) begin
            miscompares++; $display("FAIL phy_resume: ack=%b want 0010", p_ack);
        end
        tick;
        p_req = '0;
        tick;
    endtask

    task automatic test_reset_mid;
        p_req = 4'b0001; p_rnw = 4'b0001;
        tick;
        p_req = '0;
        tick;
        vectors++;
        if (rd_outstanding !== 5'd1) begin
            miscompares++; $display("FAIL mid_pre: out=%0d want 1", rd_outstanding);
        end
        reset_n = 1'b0;
        #1;
        vectors++;
        if (rd_outstanding !== 5'd0) begin
            miscompares++; $display("FAIL mid_clear: out=%0d want 0", rd_outstanding);
        end
        tick;
        reset_n = 1'b1;
        tick;
        usr_rd_dvld = 1'b1;
        tick;
        usr_rd_dvld = 1'b0;
        vectors++;
        if (p_rd_dvld !== 4'b0000 || err_underflow !== 1'b1) begin
            miscompares++; $display("FAIL mid_late_ret: dvld=%b uf=%b want 0000/1", p_rd_dvld, err_underflow);
        end
    endtask

`ifdef QDR_ARB_RD_TIMEOUT_EN
    task automatic test_timeout;
        int n;
        reset_n = 1'b0;
        tick;
        reset_n = 1'b1;
        p_req = 4'b0001; p_rnw = 4'b0001;
        tick;
        p_req = '0;
        tick; tick;
        vectors++;
        if (rd_outstanding !== 5'd1 || err_timeout !== 1'b0) begin
            miscompares++; $display("FAIL to_pre: out=%0d to=%b want 1/0", rd_outstanding, err_timeout);
        end
        n = 0;
        while (rd_outstanding !== 5'd0 && n < 60) begin
            tick;
            n++;
        end
        vectors++;
        if (n < 19 || n > 22 || err_timeout !== 1'b1) begin
            miscompares++; $display("FAIL to_flush: cycles=%0d to=%b want 19..22/1", n, err_timeout);
        end
        usr_rd_dvld = 1'b1;
        tick;
        usr_rd_dvld = 1'b0;
        vectors++;
        if (err_underflow !== 1'b1 || p_rd_dvld !== 4'b0000) begin
            miscompares++; $display("FAIL to_late_ret: uf=%b dvld=%b want 1/0000", err_underflow, p_rd_dvld);
        end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        tick;
        test_rr_writes();
        tick;
        test_reads();
        tick;
        test_fifo_full();
        test_underflow();
        tick;
        test_phy_rdy();
        test_reset_mid();
`ifdef QDR_ARB_RD_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
